pe_row_cfg_sequencer: RTL

//  Configuration/run sequencer for one PE row (LSU + PE_0..PE_3 sharing a single PE_config bus).

---
 rtl/pe_row_cfg_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pe_row_cfg_sequencer.sv
// Configuration/run sequencer for one PE row: fetches five config words, loads LSU and PE_0..PE_3
// in order over a shared PE_config bus, then holds run high for a programmed number of cycles.
module pe_row_cfg_sequencer #(
    parameter int unsigned INST_W = 64,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  run_cycles,
    input  logic              abort,
    output logic              cfg_rd_en,
    output logic [ADDR_W-1:0] cfg_addr,
    input  logic [INST_W-1:0] cfg_rd_data,
    output logic [INST_W-1:0] PE_config,
    output logic              init_en,
    output logic [4:0]        init_sel,
    output logic              run,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StLoad,
        StRun,
        StDone
    } state_e;

    localparam logic [2:0] LastIdx = 3'd4;

    state_e            state_q, state_d;
    logic [2:0]        idx_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  cycles_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [INST_W-1:0] pe_config_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // abort outranks every transition out of a busy state
    always_comb begin
        state_d = state_q;
        if (state_q != StIdle && abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start) state_d = StFetch;
                StFetch: state_d = StWait;
                StWait:  state_d = StLoad;
                StLoad: begin
                    if (idx_q < LastIdx)          state_d = StFetch;
                    else if (cycles_q != '0)      state_d = StRun;
                    else                          state_d = StDone;
                end
                StRun:   if (cnt_q == CNT_W'(1)) state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q       <= '0;
            base_q      <= '0;
            cycles_q    <= '0;
            cnt_q       <= '0;
            pe_config_q <= '0;
        end else if (state_q == StIdle) begin
            if (start) begin
                base_q   <= base_addr;
                cycles_q <= run_cycles;
                idx_q    <= '0;
            end
        end else if (abort) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                StWait: pe_config_q <= cfg_rd_data;
                StLoad: begin
                    if (idx_q < LastIdx)     idx_q <= idx_q + 3'd1;
                    else if (cycles_q != '0) cnt_q <= cycles_q;
                end
                StRun:   cnt_q <= cnt_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        cfg_rd_en = 1'b0;
        cfg_addr  = '0;
        init_en   = 1'b0;
        init_sel  = '0;
        run       = 1'b0;
        done      = 1'b0;
        busy      = (state_q != StIdle);
        unique case (state_q)
            StFetch: begin
                cfg_rd_en = 1'b1;
                cfg_addr  = base_q + ADDR_W'(idx_q);
            end
            StLoad: begin
                init_en  = 1'b1;
                init_sel = 5'b10000 >> idx_q;
            end
            StRun:   run = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign PE_config = pe_config_q;

endmodule
